mesh_term_port: RTL and testbench
=================================

MESH_TERM_PORT -- requirements
Module: mesh_term_port

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter pckg_sz, default 40, packet width in bits (min 16).
REQ-002 The block SHALL have parameter fifo_depth, default 4, entries per FIFO (power of two, >=2).
REQ-003 The block SHALL have parameters ROW_ID, default 0, and COL_ID, default 0, the 4-bit mesh coordinates of this terminal.
Ports (name, direction, width, meaning):
REQ-004 The block SHALL have a single clock and an asynchronous, active-high reset: clk  in  1  clock; reset  in  1  asynchronous active-high reset.
REQ-005 The block SHALL have these host TX ports: tx_push  in  1  write request; tx_data  in  pckg_sz  packet to send; tx_full  out  1  TX FIFO full.
REQ-006 The block SHALL have these mesh-ingress ports: pndng_i_in  out  1  packet available to mesh; data_out_i_in  out  pckg_sz  head packet to mesh; popin  in  1  mesh consumed head.
REQ-007 The block SHALL have these mesh-egress ports: pndng  in  1  mesh has packet for terminal; data_out  in  pckg_sz  mesh packet; pop  out  1  terminal consumes mesh packet.
REQ-008 The block SHALL have these host RX ports: rx_pop  in  1  host read; rx_data  out  pckg_sz  RX head; rx_pndng  out  1  RX FIFO non-empty; misroute_cnt  out  8  misdelivered-packet count.

Function
REQ-009 The TX FIFO SHALL be first-word-fall-through: data_out_i_in = head entry, pndng_i_in = (tx count != 0), data_out_i_in = 0 when empty.
REQ-010 tx_push SHALL write tx_data at the rising edge when the FIFO is not full; tx_full SHALL be (tx count == fifo_depth).
REQ-011 tx_push while full SHALL be dropped, with no state change, except when popin is high in the same cycle, where both SHALL occur and the count SHALL stay at fifo_depth.
REQ-012 popin SHALL remove the head at the rising edge when non-empty; popin while empty SHALL be ignored, and a simultaneous tx_push SHALL still be accepted.
REQ-013 Read/write pointers SHALL wrap modulo fifo_depth; the count SHALL be held separately, range 0..fifo_depth.
REQ-014 The RX drain SHALL be an FSM with states RX_IDLE, RX_POP, RX_GAP.
REQ-015 RX_IDLE SHALL go to RX_POP when pndng=1 and the RX FIFO is not full; otherwise it SHALL stay in RX_IDLE.
REQ-016 In RX_POP, pop SHALL be 1 for exactly that cycle, data_out SHALL be written into the RX FIFO, and the next state SHALL be RX_GAP.
REQ-017 RX_GAP SHALL hold pop=0 for one cycle and then return to RX_IDLE; maximum drain rate is one packet per 3 cycles; pop is a decode of state only.
REQ-018 In RX_POP, the fields row = data_out[pckg_sz-9:pckg_sz-12] and col = data_out[pckg_sz-13:pckg_sz-16] SHALL be compared to ROW_ID/COL_ID.
REQ-019 On any field mismatch, misroute_cnt SHALL increment, saturating at 255; the packet SHALL still be stored.
REQ-020 The RX FIFO SHALL be first-word-fall-through: rx_data = head (0 when empty), rx_pndng = count != 0; rx_pop removes the head when non-empty, and rx_pop while empty SHALL be ignored.
REQ-021 A simultaneous RX write and rx_pop SHALL both take effect, including when the FIFO is full.
REQ-022 RX FIFO full SHALL hold the FSM in RX_IDLE: no pop is issued and the mesh packet stays pending.

Reset
REQ-023 While reset=1, asynchronously: both FIFO counts/pointers = 0, FSM = RX_IDLE, pop=0, pndng_i_in=0, data_out_i_in=0, tx_full=0, rx_pndng=0, rx_data=0, misroute_cnt=0.
REQ-024 Reset mid-operation, including in RX_POP, SHALL discard all buffered packets, and pop SHALL drop in the same cycle.
REQ-025 After reset deassertion, the first active edge SHALL behave as from the idle state.

Verification
REQ-026 The bench SHALL cover TX fill: 5 pushes with fifo_depth=4, no popin -> tx_full=1 after push 4, 5th dropped; 4 popin -> the first four packets out in order, then pndng_i_in=0.
REQ-027 The bench SHALL cover full-plus-simultaneous: FIFO full, tx_push and popin in the same cycle -> head advances, new packet appended, tx_full stays 1.
REQ-028 The bench SHALL cover RX drain: pndng=1 with 3 packets addressed to ROW_ID/COL_ID -> pop pulses spaced exactly 3 cycles apart, rx_data order preserved, misroute_cnt=0.
REQ-029 The bench SHALL cover misroute: ROW_ID=1, packet with row=2 -> packet stored, misroute_cnt=1; 300 such packets -> misroute_cnt=255.
REQ-030 The bench SHALL cover RX backpressure: RX FIFO full, pndng=1 -> pop stays 0; one rx_pop -> pop pulse within 2 cycles.
REQ-031 The bench SHALL cover reset mid-operation: reset asserted in RX_POP with both FIFOs non-empty -> pop=0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/mesh_term_port.sv
// Mesh terminal port: host TX FIFO toward the mesh, paced RX drain from the
// mesh into a host RX FIFO, and a saturating count of misdelivered packets.

module mesh_term_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_wr,
  input  logic [W-1:0] i_wdata,
  input  logic         i_rd,
  output logic [W-1:0] o_rdata,
  output logic         o_pndng,
  output logic         o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_rd, w_wr;

  // A write into a full FIFO still lands when the head leaves in the same cycle.
  assign w_rd = i_rd && (r_cnt != '0);
  assign w_wr = i_wr && (!o_full || w_rd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_rd) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_wdata;
  end

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_pndng = (r_cnt != '0);
  assign o_rdata = o_pndng ? r_mem[r_rp] : '0;
endmodule

module mesh_term_port #(
  parameter int         pckg_sz    = 40,
  parameter int         fifo_depth = 4,
  parameter logic [3:0] ROW_ID     = 4'd0,
  parameter logic [3:0] COL_ID     = 4'd0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_push,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_full,
  output logic               pndng_i_in,
  output logic [pckg_sz-1:0] data_out_i_in,
  input  logic               popin,
  input  logic               pndng,
  input  logic [pckg_sz-1:0] data_out,
  output logic               pop,
  input  logic               rx_pop,
  output logic [pckg_sz-1:0] rx_data,
  output logic               rx_pndng,
  output logic [7:0]         misroute_cnt
);
  typedef enum logic [1:0] {RX_IDLE, RX_POP, RX_GAP} rx_state_t;

  rx_state_t  r_state;
  logic [7:0] r_mis_cnt;
  logic       w_rx_full, w_rx_wr, w_misrouted;
  logic [3:0] w_row, w_col;

  mesh_term_fifo #(.W(pckg_sz), .DEPTH(fifo_depth)) u_tx (
    .clk     (clk),
    .reset   (reset),
    .i_wr    (tx_push),
    .i_wdata (tx_data),
    .i_rd    (popin),
    .o_rdata (data_out_i_in),
    .o_pndng (pndng_i_in),
    .o_full  (tx_full)
  );

  mesh_term_fifo #(.W(pckg_sz), .DEPTH(fifo_depth)) u_rx (
    .clk     (clk),
    .reset   (reset),
    .i_wr    (w_rx_wr),
    .i_wdata (data_out),
    .i_rd    (rx_pop),
    .o_rdata (rx_data),
    .o_pndng (rx_pndng),
    .o_full  (w_rx_full)
  );

  assign w_row       = data_out[pckg_sz-9 -: 4];
  assign w_col       = data_out[pckg_sz-13 -: 4];
  assign w_misrouted = (w_row != ROW_ID) || (w_col != COL_ID);
  assign w_rx_wr     = (r_state == RX_POP);

  // pop is a pure state decode so an async reset drops it immediately.
  assign pop          = (r_state == RX_POP);
  assign misroute_cnt = r_mis_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= RX_IDLE;
      r_mis_cnt <= '0;
    end else begin
      case (r_state)
        RX_IDLE: if (pndng && !w_rx_full) r_state <= RX_POP;
        RX_POP: begin
          r_state <= RX_GAP;
          if (w_misrouted && r_mis_cnt != 8'hFF) r_mis_cnt <= r_mis_cnt + 8'd1;
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mesh_term_port.sv
// Randomized bench for mesh_term_port against a queue-based reference model.

module tb_mesh_term_port;
  localparam int PW = 40;
  localparam int DEPTH = 4;

  logic          clk, reset;
  logic          tx_push, popin, pndng, rx_pop;
  logic [PW-1:0] tx_data, data_out;
  logic          tx_full, pndng_i_in, pop, rx_pndng;
  logic [PW-1:0] data_out_i_in, rx_data;
  logic [7:0]    misroute_cnt;

  int n_chk = 0;
  int n_fail = 0;

  logic [PW-1:0] tx_q[$], rx_q[$], mesh_q[$];
  bit m_pop, m_gap;
  int m_mis;

  mesh_term_port #(.pckg_sz(PW), .fifo_depth(DEPTH), .ROW_ID(4'd1), .COL_ID(4'd2)) dut (
    .clk(clk), .reset(reset),
    .tx_push(tx_push), .tx_data(tx_data), .tx_full(tx_full),
    .pndng_i_in(pndng_i_in), .data_out_i_in(data_out_i_in), .popin(popin),
    .pndng(pndng), .data_out(data_out), .pop(pop),
    .rx_pop(rx_pop), .rx_data(rx_data), .rx_pndng(rx_pndng), .misroute_cnt(misroute_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] mk_pkt(input logic [3:0] r, input logic [3:0] c);
    mk_pkt = {8'($urandom), r, c, 24'($urandom)};
  endfunction

  function automatic logic [PW-1:0] rnd_pkt();
    rnd_pkt = {8'($urandom), 32'($urandom)};
  endfunction

  task automatic mesh_drive();
    pndng = (mesh_q.size() != 0);
    data_out = pndng ? mesh_q[0] : '0;
  endtask

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    m_pop = 0;
    m_gap = 0;
    m_mis = 0;
  endtask

  // Advances model and DUT by one clock, from posedge+1 to the next posedge+1.
  // Drain rule: a pop cycle is followed by a dead cycle; an idle cycle that
  // sees a pending mesh packet and a non-full RX FIFO makes the next cycle a pop.
  task automatic step();
    bit tpop, tpush, rpop, nxt;
    logic [PW-1:0] d;
    tpop  = popin && tx_q.size() > 0;
    tpush = tx_push && (tx_q.size() < DEPTH || tpop);
    rpop  = rx_pop && rx_q.size() > 0;
    nxt   = !m_pop && !m_gap && pndng && rx_q.size() < DEPTH;
    d     = data_out;
    if (tpop) void'(tx_q.pop_front());
    if (tpush) tx_q.push_back(tx_data);
    if (rpop) void'(rx_q.pop_front());
    if (m_pop) begin
      rx_q.push_back(d);
      if ((d[31:28] != 4'd1 || d[27:24] != 4'd2) && m_mis < 255) m_mis++;
      if (mesh_q.size() > 0) void'(mesh_q.pop_front());
    end
    m_gap = m_pop;
    m_pop = nxt;
    @(posedge clk); #1;
    mesh_drive();
  endtask

  task automatic test_reset();
    #1;
    n_chk++; if (pop !== 1'b0) begin n_fail++; $display("FAIL reset_pop got=%b exp=0", pop); end
    n_chk++; if (pndng_i_in !== 1'b0) begin n_fail++; $display("FAIL reset_pndng_i_in got=%b exp=0", pndng_i_in); end
    n_chk++; if (data_out_i_in !== '0) begin n_fail++; $display("FAIL reset_data_out_i_in got=%h exp=0", data_out_i_in); end
    n_chk++; if (tx_full !== 1'b0) begin n_fail++; $display("FAIL reset_tx_full got=%b exp=0", tx_full); end
    n_chk++; if (rx_pndng !== 1'b0) begin n_fail++; $display("FAIL reset_rx_pndng got=%b exp=0", rx_pndng); end
    n_chk++; if (rx_data !== '0) begin n_fail++; $display("FAIL reset_rx_data got=%h exp=0", rx_data); end
    n_chk++; if (misroute_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_misroute got=%0d exp=0", misroute_cnt); end
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_tx_fill();
    logic [PW-1:0] pk[5];
    for (int i = 0; i < 5; i++) begin
      pk[i] = rnd_pkt();
      tx_push = 1; tx_data = pk[i];
      step();
      n_chk++; if (tx_full !== (i >= 3)) begin n_fail++; $display("FAIL fill_tx_full push=%0d got=%b exp=%b", i+1, tx_full, i >= 3); end
    end
    tx_push = 0;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (data_out_i_in !== pk[i] || pndng_i_in !== 1'b1) begin
        n_fail++; $display("FAIL fill_order idx=%0d got=%h/%b exp=%h/1", i, data_out_i_in, pndng_i_in, pk[i]);
      end
      popin = 1;
      step();
    end
    popin = 0;
    n_chk++; if (pndng_i_in !== 1'b0 || data_out_i_in !== '0) begin
      n_fail++; $display("FAIL fill_empty got=%b/%h exp=0/0", pndng_i_in, data_out_i_in);
    end
  endtask

  task automatic test_tx_full_simul();
    logic [PW-1:0] pk[5];
    for (int i = 0; i < 5; i++) pk[i] = rnd_pkt();
    for (int i = 0; i < 4; i++) begin tx_push = 1; tx_data = pk[i]; step(); end
    tx_push = 1; popin = 1; tx_data = pk[4];
    step();
    tx_push = 0; popin = 0;
    n_chk++; if (tx_full !== 1'b1) begin n_fail++; $display("FAIL simul_tx_full got=%b exp=1", tx_full); end
    n_chk++; if (data_out_i_in !== pk[1]) begin n_fail++; $display("FAIL simul_head got=%h exp=%h", data_out_i_in, pk[1]); end
    for (int i = 1; i < 5; i++) begin
      n_chk++; if (data_out_i_in !== pk[i]) begin n_fail++; $display("FAIL simul_order idx=%0d got=%h exp=%h", i, data_out_i_in, pk[i]); end
      popin = 1; step();
    end
    popin = 0;
    n_chk++; if (pndng_i_in !== 1'b0) begin n_fail++; $display("FAIL simul_empty got=%b exp=0", pndng_i_in); end
  endtask

  task automatic test_tx_random();
    for (int i = 0; i < 300; i++) begin
      tx_push = 1'($urandom_range(0, 1));
      popin = ($urandom_range(0, 2) == 0);
      tx_data = rnd_pkt();
      step();
      n_chk++; if (tx_full !== (tx_q.size() == DEPTH) || pndng_i_in !== (tx_q.size() != 0) ||
                   data_out_i_in !== (tx_q.size() ? tx_q[0] : '0)) begin
        n_fail++; $display("FAIL tx_random cyc=%0d got=%b/%b/%h exp_cnt=%0d", i, tx_full, pndng_i_in, data_out_i_in, tx_q.size());
      end
    end
    tx_push = 0; popin = 1;
    for (int i = 0; i < DEPTH + 1; i++) step();
    popin = 0;
  endtask

  task automatic test_rx_drain();
    logic [PW-1:0] exp[3];
    int last, npop;
    for (int i = 0; i < 3; i++) begin exp[i] = mk_pkt(4'd1, 4'd2); mesh_q.push_back(exp[i]); end
    mesh_drive();
    last = -1; npop = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      n_chk++; if (pop !== m_pop) begin n_fail++; $display("FAIL drain_pop cyc=%0d got=%b exp=%b", cyc, pop, m_pop); end
      if (pop) begin
        if (npop > 0) begin
          n_chk++; if (cyc - last !== 3) begin n_fail++; $display("FAIL drain_spacing got=%0d exp=3", cyc - last); end
        end
        last = cyc; npop++;
      end
      step();
    end
    n_chk++; if (npop !== 3) begin n_fail++; $display("FAIL drain_count got=%0d exp=3", npop); end
    n_chk++; if (misroute_cnt !== 8'd0) begin n_fail++; $display("FAIL drain_misroute got=%0d exp=0", misroute_cnt); end
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (rx_data !== exp[i]) begin n_fail++; $display("FAIL drain_order idx=%0d got=%h exp=%h", i, rx_data, exp[i]); end
      rx_pop = 1; step();
    end
    rx_pop = 0;
    n_chk++; if (rx_pndng !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%b exp=0", rx_pndng); end
  endtask

  task automatic test_misroute();
    logic [PW-1:0] pk;
    int guard;
    pk = mk_pkt(4'd2, 4'd2);
    mesh_q.push_back(pk); mesh_drive();
    for (int i = 0; i < 6; i++) step();
    n_chk++; if (rx_pndng !== 1'b1 || rx_data !== pk) begin n_fail++; $display("FAIL mis_stored got=%b/%h exp=1/%h", rx_pndng, rx_data, pk); end
    n_chk++; if (misroute_cnt !== 8'd1) begin n_fail++; $display("FAIL mis_one got=%0d exp=1", misroute_cnt); end
    for (int i = 0; i < 300; i++) mesh_q.push_back(mk_pkt(4'd2, 4'($urandom)));
    mesh_drive();
    rx_pop = 1; guard = 0;
    while ((mesh_q.size() > 0 || m_pop) && guard < 1200) begin
      n_chk++; if (pop !== m_pop) begin n_fail++; $display("FAIL mis_pop cyc=%0d got=%b exp=%b", guard, pop, m_pop); end
      step(); guard++;
    end
    n_chk++; if (guard >= 1200) begin n_fail++; $display("FAIL mis_timeout got=%0d left exp=0", mesh_q.size()); end
    for (int i = 0; i < 6; i++) step();
    rx_pop = 0;
    n_chk++; if (misroute_cnt !== 8'd255 || misroute_cnt !== 8'(m_mis)) begin
      n_fail++; $display("FAIL mis_saturate got=%0d exp=255 model=%0d", misroute_cnt, m_mis);
    end
  endtask

  task automatic test_rx_backpressure();
    bit seen;
    for (int i = 0; i < 5; i++) mesh_q.push_back(mk_pkt(4'd1, 4'd2));
    mesh_drive();
    rx_pop = 0;
    for (int i = 0; i < 20; i++) begin
      if (i >= 12) begin
        n_chk++; if (pop !== 1'b0) begin n_fail++; $display("FAIL bp_hold cyc=%0d got=%b exp=0", i, pop); end
      end
      step();
    end
    rx_pop = 1; step(); rx_pop = 0;
    seen = 0;
    for (int k = 0; k < 2; k++) begin
      if (pop) seen = 1;
      n_chk++; if (pop !== m_pop) begin n_fail++; $display("FAIL bp_pop k=%0d got=%b exp=%b", k, pop, m_pop); end
      step();
    end
    n_chk++; if (!seen) begin n_fail++; $display("FAIL bp_release got=0 exp=1"); end
    rx_pop = 1;
    for (int i = 0; i < 10; i++) begin
      n_chk++; if (rx_data !== (rx_q.size() ? rx_q[0] : '0)) begin n_fail++; $display("FAIL bp_data cyc=%0d got=%h", i, rx_data); end
      step();
    end
    rx_pop = 0;
  endtask

  task automatic test_reset_mid();
    int guard;
    for (int i = 0; i < 2; i++) begin tx_push = 1; tx_data = rnd_pkt(); step(); end
    tx_push = 0;
    for (int i = 0; i < 3; i++) mesh_q.push_back(mk_pkt(4'd1, 4'd2));
    mesh_drive();
    guard = 0;
    while (!(pop && rx_q.size() > 0) && guard < 20) begin step(); guard++; end
    n_chk++; if (guard >= 20 || pop !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach got=%b exp=1", pop); end
    reset = 1; #1;
    n_chk++; if (pop !== 1'b0) begin n_fail++; $display("FAIL rstmid_pop got=%b exp=0", pop); end
    n_chk++; if (pndng_i_in !== 1'b0 || data_out_i_in !== '0 || tx_full !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_tx got=%b/%h/%b exp=0/0/0", pndng_i_in, data_out_i_in, tx_full);
    end
    n_chk++; if (rx_pndng !== 1'b0 || rx_data !== '0 || misroute_cnt !== 8'd0) begin
      n_fail++; $display("FAIL rstmid_rx got=%b/%h/%0d exp=0/0/0", rx_pndng, rx_data, misroute_cnt);
    end
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (pop !== m_pop || rx_data !== (rx_q.size() ? rx_q[0] : '0)) begin
        n_fail++; $display("FAIL rstmid_resume cyc=%0d got=%b/%h exp=%b", i, pop, rx_data, m_pop);
      end
      step();
    end
    mesh_q.delete(); mesh_drive();
    rx_pop = 1;
    for (int i = 0; i < 8; i++) step();
    rx_pop = 0;
  endtask

  initial begin
    reset = 1; tx_push = 0; popin = 0; pndng = 0; rx_pop = 0;
    tx_data = '0; data_out = '0;
    model_reset();
    test_reset();
    test_tx_fill();
    test_tx_full_simul();
    test_tx_random();
    test_rx_drain();
    test_misroute();
    test_rx_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
